adder_entry_ctrl: RTL and testbench



---
 rtl/adder_ctrl_pkg.sv | 41 ++++
 rtl/adder_entry_ctrl_if.sv | 21 ++
 rtl/seg7_decoder.sv | 25 ++
 rtl/adder_entry_ctrl.sv | 116 +++++++++++
 tb/tb_adder_entry_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the BCD adder entry controller:
// FSM states, digit-enable and segment codes, and the tens/ones split.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    function automatic logic [1:0] tens_of(input logic [4:0] value);
        if (value >= 5'd30)      return 2'd3;
        else if (value >= 5'd20) return 2'd2;
        else if (value >= 5'd10) return 2'd1;
        else                     return 2'd0;
    endfunction

    // The remainder is always below 10, so modulo-16 arithmetic is exact.
    function automatic logic [3:0] ones_of(input logic [4:0] value, input logic [1:0] tens);
        return value[3:0] - (4'(tens) * 4'd10);
    endfunction

endpackage

// File: rtl/adder_entry_ctrl_if.sv
// Operand entry and display bus of the BCD adder controller.
interface adder_entry_ctrl_if;
    logic [3:0] SW;
    logic       LOAD;
    logic       CLR;
    logic [6:0] SEG;
    logic [1:0] AN;
    logic [4:0] SUM;
    logic       VALID;
    logic [1:0] STATE;

    modport master (
        output SW, LOAD, CLR,
        input  SEG, AN, SUM, VALID, STATE
    );

    modport slave (
        input  SW, LOAD, CLR,
        output SEG, AN, SUM, VALID, STATE
    );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment code; non-decimal
// codes blank the digit.
module seg7_decoder
    import adder_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/adder_entry_ctrl.sv
// BCD adder entry sequencer with two-digit scanned display.
// Build option: define BLANK_LZ_EN to blank a leading zero in the tens digit.
//
//   state  | meaning
//   WAIT_A | showing live switches, next load captures operand A
//   WAIT_B | showing live switches, next load captures operand B and sums
//   SHOW   | showing the sum, next load clears and restarts
module adder_entry_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    adder_entry_ctrl_if.slave bus
);
    localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t           state;
    logic             load_q;
    logic             ld_evt;
    logic [3:0]       a_reg;
    logic [4:0]       sum_reg;
    logic [CNT_W-1:0] scan_cnt;
    logic             sel_tens;
    logic [6:0]       seg_reg;
    logic [1:0]       an_reg;

    logic [4:0]       disp_val;
    logic [1:0]       tens;
    logic [3:0]       ones;
    logic [3:0]       digit;
    logic [6:0]       seg_code;
    logic [6:0]       seg_next;

    assign ld_evt = bus.LOAD & ~load_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_A;
            load_q  <= 1'b0;
            a_reg   <= '0;
            sum_reg <= '0;
        end else begin
            load_q <= bus.LOAD;
            if (bus.CLR) begin
                state   <= WAIT_A;
                a_reg   <= '0;
                sum_reg <= '0;
            end else begin
                case (state)
                    WAIT_A: if (ld_evt) begin
                        a_reg <= bus.SW;
                        state <= WAIT_B;
                    end
                    WAIT_B: if (ld_evt) begin
                        sum_reg <= {1'b0, a_reg} + {1'b0, bus.SW};
                        state   <= SHOW;
                    end
                    SHOW: if (ld_evt) begin
                        a_reg   <= '0;
                        sum_reg <= '0;
                        state   <= WAIT_A;
                    end
                    default: state <= WAIT_A;
                endcase
            end
        end
    end

    always_comb begin
        disp_val = (state == SHOW) ? sum_reg : {1'b0, bus.SW};
        tens     = tens_of(disp_val);
        ones     = ones_of(disp_val, tens);
        digit    = sel_tens ? {2'b00, tens} : ones;
    end

    seg7_decoder u_seg7_decoder (
        .digit (digit),
        .seg   (seg_code)
    );

    always_comb begin
        seg_next = seg_code;
`ifdef BLANK_LZ_EN
        if (sel_tens && (tens == 2'd0)) seg_next = SEG_BLANK;
`endif
    end

    // Scan timing is independent of CLR so the display never stutters.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            sel_tens <= 1'b0;
            seg_reg  <= SEG_BLANK;
            an_reg   <= AN_OFF;
        end else begin
            if (scan_cnt == CNT_LAST) begin
                scan_cnt <= '0;
                sel_tens <= ~sel_tens;
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            an_reg  <= sel_tens ? AN_TENS : AN_ONES;
            seg_reg <= seg_next;
        end
    end

    assign bus.SEG   = seg_reg;
    assign bus.AN    = an_reg;
    assign bus.SUM   = sum_reg;
    assign bus.VALID = (state == SHOW);
    assign bus.STATE = state;

endmodule

// File: tb/tb_adder_entry_ctrl.sv
// Scoreboard bench for adder_entry_ctrl: a phase/arithmetic reference model
// queues expected outputs per cycle and sums per result; monitors compare.
module tb_adder_entry_ctrl;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adder_entry_ctrl_if bus ();

    adder_entry_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] state;
        logic       valid;
        logic [4:0] sum;
        logic [1:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t       exp_q[$];
    int         sum_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [6:0] seg_tbl [0:9];

    // Reference model: entry phase 0/1/2, operand A, sum, cycles since reset.
    int   m_phase = 0;
    int   m_a     = 0;
    int   m_sum   = 0;
    int   m_cyc   = 0;
    logic m_ld_prev = 1'b0;

`ifdef BLANK_LZ_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] sw, input logic ld, input logic cl, input logic rs);
        exp_t e;
        int   value;
        int   tens;
        int   ones;
        int   slot;
        @(negedge clk);
        bus.SW   = sw;
        bus.LOAD = ld;
        bus.CLR  = cl;
        rst      = rs;
        value = (m_phase == 2) ? m_sum : int'(sw);
        tens  = value / 10;
        ones  = value % 10;
        if (rs) begin
            m_phase = 0;
            m_a     = 0;
            m_sum   = 0;
            m_cyc   = 0;
            e.an    = 2'b11;
            e.seg   = 7'h7F;
        end else begin
            slot  = (m_cyc / DIV) % 2;
            e.an  = (slot == 1) ? 2'b01 : 2'b10;
            if (slot == 1) e.seg = (BLANK && tens == 0) ? 7'h7F : seg_tbl[tens];
            else           e.seg = seg_tbl[ones];
            m_cyc++;
            if (cl) begin
                m_phase = 0;
                m_a     = 0;
                m_sum   = 0;
            end else if (ld && !m_ld_prev) begin
                if (m_phase == 0) begin
                    m_a     = int'(sw);
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    m_sum   = m_a + int'(sw);
                    m_phase = 2;
                    sum_q.push_back(m_sum);
                end else begin
                    m_a     = 0;
                    m_sum   = 0;
                    m_phase = 0;
                end
            end
        end
        m_ld_prev = rs ? 1'b0 : ld;
        e.state = 2'(m_phase);
        e.valid = (m_phase == 2);
        e.sum   = 5'(m_sum);
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] sw);
        step(sw, 1'b1, 1'b0, 1'b0);
        step(sw, 1'b0, 1'b0, 1'b0);
    endtask

    // Per-cycle monitor plus result monitor keyed on VALID rising.
    initial begin
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state", 32'(bus.STATE), 32'(e.state));
                check("valid", 32'(bus.VALID), 32'(e.valid));
                check("sum",   32'(bus.SUM),   32'(e.sum));
                check("an",    32'(bus.AN),    32'(e.an));
                check("seg",   32'(bus.SEG),   32'(e.seg));
            end
            if (bus.VALID === 1'b1 && !prev_valid) begin
                if (sum_q.size() == 0) check("unexpected_valid", 32'(bus.VALID), 32'd0);
                else                   check("sum_on_valid", 32'(bus.SUM), 32'(sum_q.pop_front()));
            end
            prev_valid = (bus.VALID === 1'b1);
        end
    end

    initial begin
        logic ld_r;
        logic [3:0] sw_r;
        bus.SW   = 4'd0;
        bus.LOAD = 1'b0;
        bus.CLR  = 1'b0;
        seg_tbl[0] = 7'b1000000;
        seg_tbl[1] = 7'b1111001;
        seg_tbl[2] = 7'b0100100;
        seg_tbl[3] = 7'b0110000;
        seg_tbl[4] = 7'b0011001;
        seg_tbl[5] = 7'b0010010;
        seg_tbl[6] = 7'b0000010;
        seg_tbl[7] = 7'b1111000;
        seg_tbl[8] = 7'b0000000;
        seg_tbl[9] = 7'b0010000;

        // Reset values, then first scan slot after release
        repeat (3) step(4'd0, 1'b0, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b0, 1'b0);

        // 4 + 3, both scan slots of the result
        press(4'd4);
        press(4'd3);
        repeat (10) step(4'($urandom_range(15, 0)), 1'b0, 1'b0, 1'b0);
        press(4'd0);

        // 15 + 15 = 30
        press(4'd15);
        press(4'd15);
        repeat (10) step(4'd9, 1'b0, 1'b0, 1'b0);
        press(4'd0);

        // Held LOAD gives a single event
        repeat (10) step(4'd6, 1'b1, 1'b0, 1'b0);
        repeat (4) step(4'd2, 1'b0, 1'b0, 1'b0);

        // CLR beats a simultaneous load edge in WAIT_B
        step(4'd9, 1'b1, 1'b1, 1'b0);
        step(4'd9, 1'b0, 1'b0, 1'b0);
        press(4'd5);
        press(4'd2);
        repeat (4) step(4'd1, 1'b0, 1'b0, 1'b0);

        // Reset in SHOW
        step(4'd3, 1'b0, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b0, 1'b0);

        // Scan pattern with SW=12 in WAIT_A
        repeat (10) step(4'd12, 1'b0, 1'b0, 1'b0);

        // Random traffic
        ld_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            sw_r = 4'($urandom_range(15, 0));
            if ($urandom_range(2, 0) == 0) ld_r = ~ld_r;
            step(sw_r, ld_r, ($urandom_range(40, 0) == 0), ($urandom_range(150, 0) == 0));
        end
        step(4'd0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("sum_q_drained", 32'(sum_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
